load_unit: RTL and testbench

- Sequential load-path controller for the multicycle MIPS datapath; the read-side counterpart of the store-side byte/half/word merge.
- Accepts a load request (LW/LH/LHU/LB/LBU) from the control unit, issues the memory read, and waits the memory latency.
- Captures the returned word as the MDR value, extracts halfword bits [15:0] or byte bits [7:0], sign- or zero-extends the result, and returns it with a done pulse.
- Checks alignment before any memory access.

---
 rtl/load_unit.sv | 127 ++++++++++++
 tb/tb_load_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// load_unit : multicycle MIPS load path (read, wait, capture, extract, extend)
// Revision  : 1.0
// ============================================================================
module load_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] load_data,
  output logic [31:0] mdr_out
);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [3:0] LAT     = 4'(MEM_LATENCY);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t     r_state;
  logic [3:0] r_count;
  logic [1:0] r_size;
  logic       r_unsigned;

  function automatic logic is_legal(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_WORD: is_legal = (a == 2'b00);
      SZ_HALF: is_legal = ~a[0];
      SZ_BYTE: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic uns);
    logic sh;
    logic sb;
    sh = w[15] & ~uns;
    sb = w[7] & ~uns;
    case (sz)
      SZ_HALF: extract = {{16{sh}}, w[15:0]};
      SZ_BYTE: extract = {{24{sb}}, w[7:0]};
      default: extract = w;
    endcase
  endfunction

  // Request fields are latched on acceptance so later input changes cannot
  // disturb an in-flight load; mem_addr doubles as the latched address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_size     <= SZ_WORD;
      r_unsigned <= 1'b0;
      mem_addr   <= 32'd0;
      mem_rd     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      load_data  <= 32'd0;
      mdr_out    <= 32'd0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      mem_rd     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_size     <= size;
            r_unsigned <= is_unsigned;
            busy       <= 1'b1;
            if (is_legal(size, addr[1:0])) begin
              mem_addr <= addr;
              mem_rd   <= 1'b1;
              r_state  <= READ;
            end else begin
              done       <= 1'b1;
              misaligned <= 1'b1;
              r_state    <= ERR;
            end
          end
        end
        READ: begin
          r_count <= LAT;
          r_state <= WAIT;
        end
        WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            mdr_out   <= mem_rdata;
            load_data <= extract(mem_rdata, r_size, r_unsigned);
            done      <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE, ERR: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// tb_load_unit : scoreboard bench driving two load_unit instances (latency 1 and 4)
// with directed and random loads against an arithmetic reference model.
module tb_load_unit;

  localparam int LAT0 = 1;
  localparam int LAT1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start      [2];
  logic [31:0] addr       [2];
  logic [1:0]  size       [2];
  logic        uns        [2];
  logic [31:0] mem_rdata  [2];
  logic [31:0] mem_addr   [2];
  logic        mem_rd     [2];
  logic        busy       [2];
  logic        done       [2];
  logic        misaligned [2];
  logic [31:0] load_data  [2];
  logic [31:0] mdr_out    [2];

  load_unit #(.MEM_LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(rst_n), .start(start[0]), .addr(addr[0]), .size(size[0]),
    .is_unsigned(uns[0]), .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .done(done[0]),
    .misaligned(misaligned[0]), .load_data(load_data[0]), .mdr_out(mdr_out[0])
  );

  load_unit #(.MEM_LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start[1]), .addr(addr[1]), .size(size[1]),
    .is_unsigned(uns[1]), .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .done(done[1]),
    .misaligned(misaligned[1]), .load_data(load_data[1]), .mdr_out(mdr_out[1])
  );

  typedef struct {
    int          done_cyc;
    bit          err;
    logic [31:0] ld;
    logic [31:0] mdr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int          cyc = 0;
  int          cur_issue [2];
  int          cur_done  [2];
  bit          cur_err   [2];
  logic [31:0] cur_addr  [2];
  logic [31:0] prev_ld   [2];
  logic [31:0] prev_mdr  [2];
  int          cap_cyc   [2];
  logic [31:0] cap_data  [2];
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  // Reference model: alignment as divisibility, extension as modular arithmetic.
  function automatic bit legal(input logic [31:0] a, input logic [1:0] sz);
    int unsigned ua;
    ua = a;
    case (sz)
      2'd0:    return (ua % 4) == 0;
      2'd1:    return (ua % 2) == 0;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_extract(input logic [31:0] w, input logic [1:0] sz,
                                              input bit u);
    int unsigned v;
    int unsigned span;
    if (sz == 2'd0) return w;
    span = (sz == 2'd1) ? 32'd65536 : 32'd256;
    v = w % span;
    if (!u && v >= span / 2) v = v - span;
    return v;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%08h expected 0x%08h", name, d, cyc, act, exp);
    end
  endtask

  // Memory responder: valid word only in the capture cycle, garbage otherwise.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      mem_rdata[d] = (cyc == cap_cyc[d]) ? cap_data[d] : $urandom;
  end

  // Monitor: compares every cycle against the model, pops the scoreboard on done.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        bit   infl;
        bit   done_e;
        exp_t e;
        infl   = (cyc > cur_issue[d]) && (cyc <= cur_done[d]);
        done_e = infl && (cyc == cur_done[d]);
        chk("busy", d, 32'(busy[d]), 32'(infl));
        chk("mem_rd", d, 32'(mem_rd[d]), 32'(infl && !cur_err[d] && cyc == cur_issue[d] + 1));
        chk("done", d, 32'(done[d]), 32'(done_e));
        chk("misaligned", d, 32'(misaligned[d]), 32'(done_e && cur_err[d]));
        if (infl && !cur_err[d]) chk("mem_addr", d, mem_addr[d], cur_addr[d]);
        if (done[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            chk("spurious_done", d, 32'd1, 32'd0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("done_cycle", d, 32'(cyc), 32'(e.done_cyc));
            chk("done_misaligned", d, 32'(misaligned[d]), 32'(e.err));
            chk("load_data", d, load_data[d], e.ld);
            chk("mdr_out", d, mdr_out[d], e.mdr);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      addr[d]  = $urandom;
      size[d]  = 2'($urandom);
      uns[d]   = 1'($urandom);
    end
  endtask

  // Drive a start for DUT d in the current cycle; the model decides acceptance.
  task automatic step(input int d, input logic [31:0] a, input logic [1:0] sz,
                      input bit u, input logic [31:0] dat);
    exp_t e;
    start[d] = 1'b1;
    addr[d]  = a;
    size[d]  = sz;
    uns[d]   = u;
    if (cyc > cur_done[d]) begin
      cur_issue[d] = cyc;
      cur_addr[d]  = a;
      cur_err[d]   = !legal(a, sz);
      if (cur_err[d]) begin
        cur_done[d] = cyc + 1;
        e.ld  = prev_ld[d];
        e.mdr = prev_mdr[d];
      end else begin
        cur_done[d]  = cyc + 2 + lat_of(d);
        cap_cyc[d]   = cyc + 1 + lat_of(d);
        cap_data[d]  = dat;
        e.ld         = ref_extract(dat, sz, u);
        e.mdr        = dat;
        prev_ld[d]   = e.ld;
        prev_mdr[d]  = dat;
      end
      e.done_cyc = cur_done[d];
      e.err      = cur_err[d];
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    tick();
    while (cyc <= cur_done[d] + 1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("idle_timeout", d, 32'd1, 32'd0);
  endtask

  task automatic load(input int d, input logic [31:0] a, input logic [1:0] sz,
                      input bit u, input logic [31:0] dat);
    int n;
    n = 0;
    tick();
    while (cyc <= cur_done[d] && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("accept_timeout", d, 32'd1, 32'd0);
    step(d, a, sz, u, dat);
  endtask

  task automatic check_zero();
    for (int d = 0; d < 2; d++) begin
      chk("rst_mem_rd", d, 32'(mem_rd[d]), 32'd0);
      chk("rst_busy", d, 32'(busy[d]), 32'd0);
      chk("rst_done", d, 32'(done[d]), 32'd0);
      chk("rst_misaligned", d, 32'(misaligned[d]), 32'd0);
      chk("rst_mem_addr", d, mem_addr[d], 32'd0);
      chk("rst_load_data", d, load_data[d], 32'd0);
      chk("rst_mdr_out", d, mdr_out[d], 32'd0);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cur_issue[d] = cyc;
      cur_done[d]  = cyc;
      cur_err[d]   = 1'b0;
      cur_addr[d]  = 32'd0;
      prev_ld[d]   = 32'd0;
      prev_mdr[d]  = 32'd0;
      cap_cyc[d]   = -1;
      cap_data[d]  = 32'd0;
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int c;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      addr[d]  = 32'd0;
      size[d]  = 2'd0;
      uns[d]   = 1'b0;
    end
    model_reset();
    for (int d = 0; d < 2; d++) begin
      cur_issue[d] = -1;
      cur_done[d]  = -1;
    end

    repeat (2) @(posedge clk);
    #1 check_zero();
    @(negedge clk);
    rst_n = 1'b1;

    // Latency 1: word, sign/zero byte, positive half, then rejected requests.
    load(0, 32'h0000_0010, 2'b00, 1'b0, 32'hDEAD_BEEF);
    load(0, 32'h0000_0021, 2'b10, 1'b0, 32'h1234_5680);
    load(0, 32'h0000_0021, 2'b10, 1'b1, 32'h1234_5680);
    load(0, 32'h0000_0022, 2'b01, 1'b0, 32'h0000_7FFF);
    load(0, 32'h0000_0003, 2'b01, 1'b0, $urandom);
    load(0, 32'h0000_0002, 2'b00, 1'b0, $urandom);
    load(0, 32'h0000_0008, 2'b11, 1'b0, $urandom);
    wait_idle(0);

    // Latency 4: LHU with garbage before the capture edge.
    load(1, 32'h0000_0040, 2'b01, 1'b1, 32'hABCD_9001);

    // Starts in cycles 1..3 of an in-flight load must be ignored.
    load(1, 32'h0000_0100, 2'b00, 1'b0, 32'h55AA_1234);
    for (int k = 0; k < 3; k++) begin
      tick();
      step(1, 32'h0000_0200 + 32'(k * 4), 2'b00, 1'b0, $urandom);
    end
    load(1, 32'h0000_0300, 2'b00, 1'b0, 32'h0F0F_F0F0);
    wait_idle(1);

    // Random traffic on both units, including starts while busy.
    for (int k = 0; k < 600; k++) begin
      tick();
      for (int d = 0; d < 2; d++)
        if ($urandom_range(0, 2) == 0)
          step(d, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), $urandom);
    end
    wait_idle(0);
    wait_idle(1);

    // Asynchronous reset in the middle of WAIT.
    load(1, 32'h0000_0044, 2'b00, 1'b0, 32'hCAFE_0001);
    c = cur_issue[1];
    while (cyc < c + 3) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    load(1, 32'h0000_0080, 2'b00, 1'b0, 32'h1357_9BDF);
    wait_idle(1);
    wait_idle(0);

    chk("sb_empty", 0, 32'(q0.size()), 32'd0);
    chk("sb_empty", 1, 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
